// File: rtl/id_ex_stage_reg.sv
// id_ex_stage_reg
//   ID->EX pipeline register. It captures one decoded instruction per cycle
//   and presents its operand and control fields to the EX stage, which holds
//   the Val2 generator and the ALU.
//
//   Parameters
//     DATA_W : width of pc and register operand values (default 32)
//     CNT_W  : width of the optional performance counters (default 16)
//
//   Ports
//     clk, rst_n          rising-edge clock, asynchronous active-low reset
//     freeze              hazard stall: every output holds its value
//     flush               branch taken: load a bubble (takes priority over freeze)
//     valid_in            ID holds a real instruction
//     *_in                decoded fields from ID
//     *_out               registered copies of the *_in fields
//     mem_en_out          registered (mem_r_en_in | mem_w_en_in), feeds Val2
//     valid_out           EX holds a real instruction
//
//   Optional feature, macro ID_EX_PERF_EN:
//     freeze_cnt_out      cycles stalled while EX holds a valid instruction
//     bubble_cnt_out      cycles in which a bubble was loaded
//     Both counters saturate at all-ones.
module id_ex_stage_reg #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              freeze,
  input  logic              flush,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [DATA_W-1:0] val_Rn_in,
  input  logic [DATA_W-1:0] val_Rm_in,
  input  logic [11:0]       shifter_operand_in,
  input  logic              imm_in,
  input  logic [23:0]       signed_imm_24_in,
  input  logic [3:0]        dest_in,
  input  logic [3:0]        src1_in,
  input  logic [3:0]        src2_in,
  input  logic [3:0]        exe_cmd_in,
  input  logic [3:0]        status_in,
  input  logic              wb_en_in,
  input  logic              mem_r_en_in,
  input  logic              mem_w_en_in,
  input  logic              b_in,
  input  logic              s_in,
  output logic [DATA_W-1:0] pc_out,
  output logic [DATA_W-1:0] val_Rn_out,
  output logic [DATA_W-1:0] val_Rm_out,
  output logic [11:0]       shifter_operand_out,
  output logic              imm_out,
  output logic [23:0]       signed_imm_24_out,
  output logic [3:0]        dest_out,
  output logic [3:0]        src1_out,
  output logic [3:0]        src2_out,
  output logic [3:0]        exe_cmd_out,
  output logic [3:0]        status_out,
  output logic              wb_en_out,
  output logic              mem_r_en_out,
  output logic              mem_w_en_out,
  output logic              b_out,
  output logic              s_out,
  output logic              mem_en_out,
  output logic              valid_out
`ifdef ID_EX_PERF_EN
  ,
  output logic [CNT_W-1:0]  freeze_cnt_out,
  output logic [CNT_W-1:0]  bubble_cnt_out
`endif
);

  if (CNT_W < 1) begin : g_cnt_w_check
    $error("CNT_W must be at least 1");
  end

  logic capture;
  assign capture = !flush && !freeze;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_out              <= '0;
      val_Rn_out          <= '0;
      val_Rm_out          <= '0;
      shifter_operand_out <= '0;
      imm_out             <= 1'b0;
      signed_imm_24_out   <= '0;
      dest_out            <= '0;
      src1_out            <= '0;
      src2_out            <= '0;
      exe_cmd_out         <= '0;
      status_out          <= '0;
      wb_en_out           <= 1'b0;
      mem_r_en_out        <= 1'b0;
      mem_w_en_out        <= 1'b0;
      b_out               <= 1'b0;
      s_out               <= 1'b0;
      mem_en_out          <= 1'b0;
      valid_out           <= 1'b0;
    end else if (flush) begin
      pc_out              <= '0;
      val_Rn_out          <= '0;
      val_Rm_out          <= '0;
      shifter_operand_out <= '0;
      imm_out             <= 1'b0;
      signed_imm_24_out   <= '0;
      dest_out            <= '0;
      src1_out            <= '0;
      src2_out            <= '0;
      exe_cmd_out         <= '0;
      status_out          <= '0;
      wb_en_out           <= 1'b0;
      mem_r_en_out        <= 1'b0;
      mem_w_en_out        <= 1'b0;
      b_out               <= 1'b0;
      s_out               <= 1'b0;
      mem_en_out          <= 1'b0;
      valid_out           <= 1'b0;
    end else if (capture) begin
      pc_out              <= pc_in;
      val_Rn_out          <= val_Rn_in;
      val_Rm_out          <= val_Rm_in;
      shifter_operand_out <= shifter_operand_in;
      imm_out             <= imm_in;
      signed_imm_24_out   <= signed_imm_24_in;
      dest_out            <= dest_in;
      src1_out            <= src1_in;
      src2_out            <= src2_in;
      exe_cmd_out         <= exe_cmd_in;
      status_out          <= status_in;
      // Side-effect controls are gated by valid_in so a bubble can never
      // write registers, memory or flags, or redirect the pc.
      wb_en_out           <= wb_en_in    & valid_in;
      mem_r_en_out        <= mem_r_en_in & valid_in;
      mem_w_en_out        <= mem_w_en_in & valid_in;
      b_out               <= b_in        & valid_in;
      s_out               <= s_in        & valid_in;
      mem_en_out          <= (mem_r_en_in | mem_w_en_in) & valid_in;
      valid_out           <= valid_in;
    end
  end

`ifdef ID_EX_PERF_EN
  logic load_bubble;
  logic count_freeze;
  assign load_bubble  = flush || (capture && !valid_in);
  assign count_freeze = freeze && !flush && valid_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      freeze_cnt_out <= '0;
      bubble_cnt_out <= '0;
    end else begin
      if (count_freeze && (freeze_cnt_out != '1))
        freeze_cnt_out <= freeze_cnt_out + 1'b1;
      if (load_bubble && (bubble_cnt_out != '1))
        bubble_cnt_out <= bubble_cnt_out + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
module tb_id_ex_stage_reg;

`ifdef ID_EX_PERF_EN
  localparam int unsigned CW = 4;
`else
  localparam int unsigned CW = 16;
`endif

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rn;
    logic [31:0] rm;
    logic [11:0] shop;
    logic        imm;
    logic [23:0] simm;
    logic [3:0]  dest;
    logic [3:0]  src1;
    logic [3:0]  src2;
    logic [3:0]  cmd;
    logic [3:0]  status;
    logic        wb;
    logic        mr;
    logic        mw;
    logic        b;
    logic        s;
    logic        mem_en;   // ignored on the input side
  } ex_t;

  typedef struct {
    string name;
    ex_t   in;
    logic  fz;
    logic  fl;
    ex_t   exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic freeze = 1'b0;
  logic flush = 1'b0;
  ex_t  in_s = '0;
  ex_t  act;
  ex_t  model = '0;
  int   fc_model = 0;
  int   bc_model = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  logic [31:0] pc_o, rn_o, rm_o;
  logic [11:0] shop_o;
  logic        imm_o;
  logic [23:0] simm_o;
  logic [3:0]  dest_o, src1_o, src2_o, cmd_o, status_o;
  logic        wb_o, mr_o, mw_o, b_o, s_o, mem_en_o, valid_o;
  logic [CW-1:0] fcnt_o, bcnt_o;

  always #5 clk = ~clk;

  id_ex_stage_reg #(.DATA_W(32), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .freeze(freeze), .flush(flush),
    .valid_in(in_s.valid), .pc_in(in_s.pc), .val_Rn_in(in_s.rn), .val_Rm_in(in_s.rm),
    .shifter_operand_in(in_s.shop), .imm_in(in_s.imm), .signed_imm_24_in(in_s.simm),
    .dest_in(in_s.dest), .src1_in(in_s.src1), .src2_in(in_s.src2),
    .exe_cmd_in(in_s.cmd), .status_in(in_s.status), .wb_en_in(in_s.wb),
    .mem_r_en_in(in_s.mr), .mem_w_en_in(in_s.mw), .b_in(in_s.b), .s_in(in_s.s),
    .pc_out(pc_o), .val_Rn_out(rn_o), .val_Rm_out(rm_o),
    .shifter_operand_out(shop_o), .imm_out(imm_o), .signed_imm_24_out(simm_o),
    .dest_out(dest_o), .src1_out(src1_o), .src2_out(src2_o),
    .exe_cmd_out(cmd_o), .status_out(status_o), .wb_en_out(wb_o),
    .mem_r_en_out(mr_o), .mem_w_en_out(mw_o), .b_out(b_o), .s_out(s_o),
    .mem_en_out(mem_en_o), .valid_out(valid_o)
`ifdef ID_EX_PERF_EN
    , .freeze_cnt_out(fcnt_o), .bubble_cnt_out(bcnt_o)
`endif
  );

`ifndef ID_EX_PERF_EN
  assign fcnt_o = '0;
  assign bcnt_o = '0;
`endif

  always_comb begin
    act        = '0;
    act.valid  = valid_o;
    act.pc     = pc_o;
    act.rn     = rn_o;
    act.rm     = rm_o;
    act.shop   = shop_o;
    act.imm    = imm_o;
    act.simm   = simm_o;
    act.dest   = dest_o;
    act.src1   = src1_o;
    act.src2   = src2_o;
    act.cmd    = cmd_o;
    act.status = status_o;
    act.wb     = wb_o;
    act.mr     = mr_o;
    act.mw     = mw_o;
    act.b      = b_o;
    act.s      = s_o;
    act.mem_en = mem_en_o;
  end

  // What EX should hold after one clock: a bubble on flush, the old contents
  // on freeze, otherwise the ID instruction with its side effects suppressed
  // when it is not real.
  function automatic ex_t expect_next(input ex_t cur, input ex_t id, input logic fz, input logic fl);
    ex_t r;
    if (fl) return '0;
    if (fz) return cur;
    r = id;
    if (!id.valid) begin
      r.wb = 1'b0; r.mr = 1'b0; r.mw = 1'b0; r.b = 1'b0; r.s = 1'b0;
    end
    r.mem_en = id.valid && (id.mr || id.mw);
    return r;
  endfunction

  function automatic int sat_inc(input int v);
    return (v + 1 > (1 << CW) - 1) ? v : v + 1;
  endfunction

  function automatic ex_t rand_instr();
    ex_t r;
    r.valid  = ($urandom_range(0, 3) != 0);
    r.pc     = $urandom; r.rn = $urandom; r.rm = $urandom;
    r.shop   = 12'($urandom); r.imm = 1'($urandom);
    r.simm   = 24'($urandom);
    r.dest   = 4'($urandom); r.src1 = 4'($urandom); r.src2 = 4'($urandom);
    r.cmd    = 4'($urandom); r.status = 4'($urandom);
    r.wb = 1'($urandom); r.mr = 1'($urandom); r.mw = 1'($urandom);
    r.b = 1'($urandom); r.s = 1'($urandom);
    r.mem_en = 1'($urandom);
    return r;
  endfunction

  // Drive controls, advance the model, then sample 1 time unit after the edge.
  task automatic step(input logic fz, input logic fl);
    freeze = fz;
    flush  = fl;
    if (fz && !fl && model.valid) fc_model = sat_inc(fc_model);
    if (fl || (!fz && !in_s.valid)) bc_model = sat_inc(bc_model);
    model = expect_next(model, in_s, fz, fl);
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input ex_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic check_cnt(input string name);
`ifdef ID_EX_PERF_EN
    n_tests++;
    if (fcnt_o !== CW'(fc_model) || bcnt_o !== CW'(bc_model)) begin
      n_fail++;
      $display("FAIL %s: got freeze_cnt=%0d bubble_cnt=%0d want %0d %0d",
               name, fcnt_o, bcnt_o, fc_model, bc_model);
    end
`else
    if (name.len() == 0) $display("empty check name");
`endif
  endtask

  task automatic async_reset(input string name);
    #2;
    rst_n = 1'b0;
    #1;
    model = '0; fc_model = 0; bc_model = 0;
    check(name, '0);
    check_cnt({name, "_cnt"});
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  vec_t vecs[5];

  initial begin
    ex_t a, b;

    // Fixed vectors; the expected record is written out per case.
    vecs[0].name = "basic_capture";
    vecs[0].in = '0; vecs[0].in.valid = 1'b1; vecs[0].in.rm = 32'h8000_0001;
    vecs[0].in.shop = 12'h0E3; vecs[0].in.mw = 1'b1; vecs[0].in.pc = 32'h0000_0104;
    vecs[0].fz = 1'b0; vecs[0].fl = 1'b0;
    vecs[0].exp = vecs[0].in; vecs[0].exp.mem_en = 1'b1;

    vecs[1].name = "flush_over_freeze";
    vecs[1].in = '1; vecs[1].in.wb = 1'b1;
    vecs[1].fz = 1'b1; vecs[1].fl = 1'b1;
    vecs[1].exp = '0;

    vecs[2].name = "invalid_capture";
    vecs[2].in = '0; vecs[2].in.wb = 1'b1; vecs[2].in.b = 1'b1; vecs[2].in.mr = 1'b1;
    vecs[2].in.s = 1'b1; vecs[2].in.rn = 32'd7; vecs[2].in.dest = 4'hA;
    vecs[2].fz = 1'b0; vecs[2].fl = 1'b0;
    vecs[2].exp = '0; vecs[2].exp.rn = 32'd7; vecs[2].exp.dest = 4'hA;

    vecs[3].name = "all_ones";
    vecs[3].in = '1; vecs[3].in.mem_en = 1'b0;
    vecs[3].fz = 1'b0; vecs[3].fl = 1'b0;
    vecs[3].exp = '1;

    vecs[4].name = "read_imm_no_extend";
    vecs[4].in = '0; vecs[4].in.valid = 1'b1; vecs[4].in.mr = 1'b1; vecs[4].in.imm = 1'b1;
    vecs[4].in.simm = 24'h80_0001; vecs[4].in.cmd = 4'h9; vecs[4].in.status = 4'b1010;
    vecs[4].fz = 1'b0; vecs[4].fl = 1'b0;
    vecs[4].exp = vecs[4].in; vecs[4].exp.mem_en = 1'b1;

    @(negedge clk);
    #1;
    check("reset_state", '0);
    check_cnt("reset_cnt");
    @(negedge clk);
    rst_n = 1'b1;

`ifdef ID_EX_PERF_EN
    // Counter saturation: a valid instruction frozen 20 cycles, then 2 flushes.
    in_s = rand_instr(); in_s.valid = 1'b1;
    step(1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0);
    n_tests++;
    if (fcnt_o !== 4'hF || bcnt_o !== 4'h0) begin
      n_fail++;
      $display("FAIL freeze_sat: got freeze_cnt=%0d bubble_cnt=%0d want 15 0", fcnt_o, bcnt_o);
    end
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    n_tests++;
    if (bcnt_o !== 4'h2 || fcnt_o !== 4'hF) begin
      n_fail++;
      $display("FAIL bubble_cnt: got freeze_cnt=%0d bubble_cnt=%0d want 15 2", fcnt_o, bcnt_o);
    end
`endif

    for (int i = 0; i < 5; i++) begin
      in_s = vecs[i].in;
      step(vecs[i].fz, vecs[i].fl);
      check(vecs[i].name, vecs[i].exp);
    end

    // Freeze for 3 cycles while ID moves on to instruction B.
    a = rand_instr(); a.valid = 1'b1; a.dest = 4'd5;
    b = rand_instr(); b.valid = 1'b1; b.dest = 4'd9;
    in_s = a;
    step(1'b0, 1'b0);
    n_tests++;
    if (dest_o !== 4'd5) begin n_fail++; $display("FAIL freeze_load_a: got dest=%0d want 5", dest_o); end
    in_s = b;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0);
      n_tests++;
      if (dest_o !== 4'd5 || valid_o !== 1'b1) begin
        n_fail++;
        $display("FAIL freeze_hold: got dest=%0d valid=%0b want 5 1", dest_o, valid_o);
      end
    end
    step(1'b0, 1'b0);
    n_tests++;
    if (dest_o !== 4'd9) begin n_fail++; $display("FAIL freeze_release: got dest=%0d want 9", dest_o); end
    check("freeze_release_full", model);

    // Asynchronous reset mid-stream with a valid instruction in EX.
    in_s = a;
    step(1'b0, 1'b0);
    check("pre_reset_valid", model);
    async_reset("async_reset");

    // Randomised traffic against the model, with an occasional reset.
    for (int i = 0; i < 400; i++) begin
      in_s = rand_instr();
      step(($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0));
      check("random", model);
      check_cnt("random_cnt");
      if (i == 200) async_reset("random_reset");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
